// File: rtl/qam_ber_pkg.sv
// qam_ber_pkg: shared state encoding, default parameters and saturating increment for the BER checker
package qam_ber_pkg;
    typedef enum logic [1:0] {FILL, SEARCH, LOCKED} state_t;
    localparam int MAX_DELAY_DEF     = 32;
    localparam int DLY_W_DEF         = 5;
    localparam int WINDOW_DEF        = 64;
    localparam int LOCK_THRESH_DEF   = 2;
    localparam int UNLOCK_THRESH_DEF = 8;
    localparam int CNT_W_DEF         = 32;
    // Increment v but stick at the all-ones value of a w-bit counter
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] top;
        top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= top) ? v : v + 64'd1;
    endfunction
endpackage

// File: rtl/qam_ber_if.sv
// qam_ber_if: serial compare inputs and lock/count results of the BER checker
interface qam_ber_if import qam_ber_pkg::*; #(
    parameter int DLY_W = DLY_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             ref_bit;
    logic             rx_bit;
    logic             clear;
    logic             locked;
    logic             err_pulse;
    logic [DLY_W-1:0] delay;
    logic [CNT_W-1:0] bit_count;
    logic [CNT_W-1:0] err_count;
    modport master (output ref_bit, rx_bit, clear, input locked, delay, bit_count, err_count, err_pulse);
    modport slave  (input ref_bit, rx_bit, clear, output locked, delay, bit_count, err_count, err_pulse);
endinterface

// File: rtl/qam_ber_checker_ref_delay_line.sv
// ref_delay_line: history of ref_bit with a tap selected by delay; tap 0 is the live input
module ref_delay_line import qam_ber_pkg::*; #(
    parameter int MAX_DELAY = MAX_DELAY_DEF,
    parameter int DLY_W     = DLY_W_DEF
) (
    input  logic             signal_clk,
    input  logic             reset_n,
    input  logic             ref_bit,
    input  logic [DLY_W-1:0] delay,
    output logic             tap
);
    logic [MAX_DELAY-2:0] hist;
    logic [MAX_DELAY-1:0] taps;
    assign taps = {hist, ref_bit};
    assign tap  = taps[delay];
    always_ff @(posedge signal_clk) begin
        if (!reset_n) hist <= '0;
        else          hist <= taps[MAX_DELAY-2:0];
    end
endmodule

// File: rtl/qam_ber_checker.sv
// qam_ber_checker: finds the demodulator delay by windowed search, locks, and counts bits/errors
module qam_ber_checker import qam_ber_pkg::*; #(
    parameter int MAX_DELAY     = MAX_DELAY_DEF,
    parameter int DLY_W         = DLY_W_DEF,
    parameter int WINDOW        = WINDOW_DEF,
    parameter int LOCK_THRESH   = LOCK_THRESH_DEF,
    parameter int UNLOCK_THRESH = UNLOCK_THRESH_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input logic       signal_clk,
    input logic       reset_n,
    qam_ber_if.slave  bus
);
    localparam int WC_W = $clog2((WINDOW > MAX_DELAY ? WINDOW : MAX_DELAY) + 1);
    localparam int MC_W = $clog2(WINDOW + 1);
    state_t           state;
    logic [WC_W-1:0]  win_cnt;
    logic [MC_W-1:0]  mis_cnt;
    logic [MC_W-1:0]  mis_total;
    logic [DLY_W-1:0] next_delay;
    logic [63:0]      bit_inc;
    logic [63:0]      err_inc;
    logic             tap;
    logic             mismatch;
    logic             win_end;
    logic             fill_end;
    ref_delay_line #(.MAX_DELAY(MAX_DELAY), .DLY_W(DLY_W)) u_dl (
        .signal_clk(signal_clk),
        .reset_n   (reset_n),
        .ref_bit   (bus.ref_bit),
        .delay     (bus.delay),
        .tap       (tap)
    );
    assign mismatch   = bus.rx_bit ^ tap;
    assign mis_total  = mis_cnt + MC_W'(mismatch);
    assign win_end    = win_cnt == WC_W'(WINDOW - 1);
    assign fill_end   = win_cnt == WC_W'(MAX_DELAY - 2);
    assign next_delay = (bus.delay == DLY_W'(MAX_DELAY - 1)) ? '0 : bus.delay + DLY_W'(1);
    assign bit_inc    = sat_inc(64'(bus.bit_count), CNT_W);
    assign err_inc    = sat_inc(64'(bus.err_count), CNT_W);
    // Window/mismatch counters free-run and are zeroed on every state entry or window restart
    always_ff @(posedge signal_clk) begin
        if (!reset_n) begin
            state         <= FILL;
            win_cnt       <= '0;
            mis_cnt       <= '0;
            bus.locked    <= 1'b0;
            bus.delay     <= '0;
            bus.bit_count <= '0;
            bus.err_count <= '0;
            bus.err_pulse <= 1'b0;
        end else begin
            bus.err_pulse <= (state == LOCKED) && mismatch;
            if (bus.clear) begin
                bus.bit_count <= '0;
                bus.err_count <= '0;
            end else if (state == LOCKED) begin
                bus.bit_count <= bit_inc[CNT_W-1:0];
                if (mismatch) bus.err_count <= err_inc[CNT_W-1:0];
            end
            win_cnt <= win_cnt + WC_W'(1);
            mis_cnt <= mis_total;
            case (state)
                FILL: if (fill_end) begin
                    state   <= SEARCH;
                    win_cnt <= '0;
                    mis_cnt <= '0;
                end
                SEARCH: if (win_end) begin
                    win_cnt <= '0;
                    mis_cnt <= '0;
                    if (mis_total <= MC_W'(LOCK_THRESH)) begin
                        state      <= LOCKED;
                        bus.locked <= 1'b1;
                    end else begin
                        bus.delay <= next_delay;
                    end
                end
                LOCKED: if (win_end) begin
                    win_cnt <= '0;
                    mis_cnt <= '0;
                    if (mis_total > MC_W'(UNLOCK_THRESH)) begin
                        state      <= SEARCH;
                        bus.locked <= 1'b0;
                        bus.delay  <= next_delay;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: doc/qam_ber_checker.md
# qam_ber_checker

Bit-error-rate checker that sits directly downstream of the 16QAM modulator/demodulator pair. It compares the demodulated serial stream against the modulator's serial input. It finds the unknown demodulator pipeline delay automatically, locks to it, then counts received bits and bit errors for link characterisation in simulation and on hardware.

## Interface
- `MAX_DELAY`, default 32: number of candidate delays searched (0..MAX_DELAY-1).
- `DLY_W`, default 5: width of the delay index; must satisfy 2^DLY_W >= MAX_DELAY.
- `WINDOW`, default 64: bits per search/monitor window.
- `LOCK_THRESH`, default 2: maximum mismatches in one window that still allows lock.
- `UNLOCK_THRESH`, default 8: more mismatches than this in one locked window drops lock.
- `CNT_W`, default 32: width of the bit and error counters.
- `signal_clk` input 1: the single clock, the symbol/bit-rate clock of the link.
- `reset_n` input 1: synchronous, active-low reset.
- `ref_bit` input 1: modulator serial input bit, valid every cycle.
- `rx_bit` input 1: demodulator serial output bit, valid every cycle.
- `clear` input 1: synchronous clear of `bit_count` and `err_count`; does not affect lock.
- `locked` output 1: alignment found.
- `delay` output DLY_W: current candidate delay when searching, or the locked delay.
- `bit_count` output CNT_W: bits compared while locked; saturates.
- `err_count` output CNT_W: mismatches while locked; saturates.
- `err_pulse` output 1: one-cycle pulse for each locked mismatch.

## Operation
- Reference history: the candidate for delay d is `ref_bit` from d cycles earlier. d=0 means the current `ref_bit`.
- Mismatch: `rx_bit` differs from the reference tap at the current `delay`.
- States:
  - FILL: held for MAX_DELAY-1 cycles after reset so the history register is full. Then go to SEARCH with delay=0.
  - SEARCH: count mismatches over WINDOW consecutive samples.
    - At the last sample of the window, if total mismatches <= LOCK_THRESH, go to LOCKED and keep `delay`.
    - Otherwise increment `delay`, wrapping from MAX_DELAY-1 to 0, restart the window and stay in SEARCH.
    - The search repeats indefinitely if no delay qualifies.
  - LOCKED: every sample increments `bit_count`. Each mismatch increments `err_count` and raises `err_pulse`.
    - A monitor window counts mismatches over WINDOW samples. At the window's last sample, if the count > UNLOCK_THRESH, go to SEARCH with delay = (delay+1) mod MAX_DELAY.
    - `bit_count` and `err_count` hold their values while not LOCKED.
- Window and mismatch counters restart at every state entry.
- Counters saturate at all-ones independently; they never wrap.
- `clear` zeroes both counters. If `clear` arrives in the same cycle as an increment, `clear` wins and the result is 0.
- Reset, including mid-operation, returns all outputs to 0 and the state to FILL: `locked`=0, `delay`=0, counts=0, `err_pulse`=0.

## Timing
- All outputs are registered.
- A sample at cycle t updates `bit_count`, `err_count` and `err_pulse` at t+1.
- `locked` rises at cycle t+1, where t is the last sample of the qualifying window.
- `locked` falls at t+1 after the failing monitor window.
- With a true delay D and a clean link, lock occurs MAX_DELAY-1 + (D+1)*WINDOW + 1 cycles after reset release.
- `delay` changes at t+1 after each failed search window.

## Structure
- Shared package `qam_ber_pkg`:
  - state encoding FILL/SEARCH/LOCKED
  - default parameter constants
  - saturating-increment function
- Sub-module `ref_delay_line`:
  - MAX_DELAY-1 stage shift register of `ref_bit`
  - tap multiplexer indexed by `delay`
  - output is a combinational tap selected from registered history
- Top level holds the FSM, the window/mismatch counters and the output counters.

## Test plan
- Clean link with `rx_bit` = `ref_bit` delayed 7 cycles and PRBS7 data, defaults → `locked`=1 at cycle 31+512+1=544 after reset, `delay`=7, `err_count`=0, `bit_count` increases by 1 per cycle.
- Locked with one inverted `rx_bit` every 100 bits over 10000 bits → `err_count`=100, `bit_count`=10000, 100 single-cycle `err_pulse`s each one cycle after the corrupted sample, `locked` stays 1.
- Locked, then `rx_bit` inverted permanently → `locked` drops at the end of the current 64-bit monitor window and `delay` becomes 8. Counters then hold, and search continues without locking.
- `clear` asserted during locked counting in the same cycle as an error → both counts read 0 the next cycle, `locked` unchanged, and counting resumes the cycle after.
- CNT_W=4 with 20 locked bits → `bit_count` sticks at 15 and does not wrap to 0.
- `reset_n` low for one cycle while locked → next cycle all outputs are 0, and relock timing matches the first scenario.
